idli_instr_ser_m: RTL and testbench

//  Instruction nibble serialiser: the transmit end of the 4-bit decode interface.

---
 rtl/idli_instr_ser_m.sv | 131 +++++++++++++
 tb/tb_idli_instr_ser_m.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/idli_instr_ser_m.sv
// Instruction nibble serialiser: buffers 16-bit words and emits each as four nibbles, LSB first.
// Optional macro IDLI_SER_BYPASS_EN lets a word arriving at an idle, empty serialiser skip the FIFO.
module idli_instr_ser_m #(
  parameter int DEPTH = 2
) (
  input  logic        i_ser_gck,
  input  logic        i_ser_rst,
  input  logic [15:0] i_ser_instr,
  input  logic        i_ser_instr_vld,
  output logic        o_ser_instr_rdy,
  input  logic        i_ser_flush,
  output logic [3:0]  o_ser_enc,
  output logic        o_ser_enc_vld,
  output logic        o_ser_busy,
  output logic        o_ser_idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

  state_t         state_q, state_d;
  logic [15:0]    fifo_q [DEPTH];
  logic [PW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]  count_q;
  logic [11:0]    shreg_q;

  logic        fifo_empty, fifo_full;
  logic        push, pop, start_fifo, bypass, start;
  logic [15:0] start_word;

  // Handshake: a word transfers at a posedge where i_ser_instr_vld & o_ser_instr_rdy are both
  // high; rdy depends only on FIFO occupancy, never on vld, and a flush discards the transfer.
  assign fifo_empty      = (count_q == '0);
  assign fifo_full       = (count_q == CW'(DEPTH));
  assign o_ser_instr_rdy = !fifo_full;

  assign start_fifo = (state_q == S0) && !fifo_empty && !i_ser_flush;

`ifdef IDLI_SER_BYPASS_EN
  assign bypass = !i_ser_rst && (state_q == S0) && fifo_empty && !i_ser_flush && i_ser_instr_vld;
`else
  assign bypass = 1'b0;
`endif

  assign start      = start_fifo || bypass;
  assign start_word = bypass ? i_ser_instr : fifo_q[rd_ptr_q];
  assign push       = i_ser_instr_vld && o_ser_instr_rdy && !i_ser_flush && !bypass;
  assign pop        = start_fifo;

  // State register
  always_ff @(posedge i_ser_gck or posedge i_ser_rst) begin
    if (i_ser_rst) state_q <= S0;
    else           state_q <= state_d;
  end

  // Next-state logic: once started, an instruction always runs through S1..S3
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S0: state_d = start ? S1 : S0;
      S1: state_d = S2;
      S2: state_d = S3;
      S3: state_d = S0;
      default: state_d = S0;
    endcase
  end

  // Output logic
  always_comb begin
    o_ser_enc     = 4'h0;
    o_ser_enc_vld = 1'b0;
    o_ser_busy    = 1'b0;
    unique case (state_q)
      S0: begin
        if (start) begin
          o_ser_enc     = start_word[3:0];
          o_ser_enc_vld = 1'b1;
        end
      end
      S1: begin
        o_ser_enc  = shreg_q[3:0];
        o_ser_busy = 1'b1;
      end
      S2: begin
        o_ser_enc  = shreg_q[7:4];
        o_ser_busy = 1'b1;
      end
      S3: begin
        o_ser_enc  = shreg_q[11:8];
        o_ser_busy = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_ser_idle = (state_q == S0) && fifo_empty;

  // FIFO storage needs no reset: occupancy is tracked by count_q alone
  always_ff @(posedge i_ser_gck) begin
    if (push) fifo_q[wr_ptr_q] <= i_ser_instr;
  end

  // Flush outranks push and pop
  always_ff @(posedge i_ser_gck or posedge i_ser_rst) begin
    if (i_ser_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (i_ser_flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_ser_gck or posedge i_ser_rst) begin
    if (i_ser_rst)  shreg_q <= '0;
    else if (start) shreg_q <= start_word[15:4];
  end

endmodule

// File: tb/tb_idli_instr_ser_m.sv
// Bench for idli_instr_ser_m (default build): random and directed traffic against a word-level
// model of accepted-but-unstarted instructions, checked nibble by nibble by a negedge monitor.
module tb_idli_instr_ser_m;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        vld;
  logic        flush;
  logic        rdy;
  logic [3:0]  enc;
  logic        enc_vld;
  logic        busy;
  logic        idle;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Words accepted but not yet started, in order
  logic [15:0] exp_q[$];
  logic [15:0] cur_word;
  int          phase = 0;

  idli_instr_ser_m #(.DEPTH(DEPTH)) dut (
    .i_ser_gck       (clk),
    .i_ser_rst       (rst),
    .i_ser_instr     (instr),
    .i_ser_instr_vld (vld),
    .o_ser_instr_rdy (rdy),
    .i_ser_flush     (flush),
    .o_ser_enc       (enc),
    .o_ser_enc_vld   (enc_vld),
    .o_ser_busy      (busy),
    .o_ser_idle      (idle)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp_v);
    chk_cnt++;
    if (act == exp_v) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
  endtask

  // Driver: inputs change 1 time unit after the posedge and hold for one cycle
  task automatic step(input logic v, input logic [15:0] w, input logic f);
    vld   = v;
    instr = w;
    flush = f;
    @(posedge clk);
    #1;
    vld   = 1'b0;
    flush = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(phase == 0 && exp_q.size() == 0) && n < 200) begin
      step(1'b0, 16'h0, 1'b0);
      n++;
    end
    chk("drain_timeout", (n < 200) ? 1 : 0, 1);
    step(1'b0, 16'h0, 1'b0);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    int n;
    if (rst) begin
      chk("rst_enc", enc, 0);
      chk("rst_enc_vld", enc_vld, 0);
      chk("rst_busy", busy, 0);
      chk("rst_idle", idle, 1);
      chk("rst_rdy", rdy, 1);
      exp_q.delete();
      phase = 0;
    end else begin
      n = exp_q.size();
      chk("rdy", rdy, (n != DEPTH) ? 1 : 0);
      chk("idle", idle, (phase == 0 && n == 0) ? 1 : 0);
      if (phase == 0) begin
        if (n > 0 && !flush) begin
          cur_word = exp_q.pop_front();
          chk("enc_vld_start", enc_vld, 1);
          chk("nibble0", enc, int'(cur_word[3:0]));
          chk("busy_start", busy, 0);
          phase = 1;
        end else begin
          chk("enc_vld_quiet", enc_vld, 0);
          chk("enc_quiet", enc, 0);
          chk("busy_quiet", busy, 0);
        end
      end else begin
        chk("enc_vld_mid", enc_vld, 0);
        chk("nibble_mid", enc, int'(cur_word[phase*4 +: 4]));
        chk("busy_mid", busy, 1);
        phase = (phase == 3) ? 0 : phase + 1;
      end
      if (flush) exp_q.delete();
      else if (vld && n != DEPTH) exp_q.push_back(instr);
    end
  end

  initial begin
    rst   = 1'b1;
    vld   = 1'b0;
    flush = 1'b0;
    instr = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single word
    step(1'b1, 16'hA5C3, 1'b0);
    drain();

    // Back-to-back words, FIFO fills
    step(1'b1, 16'h1234, 1'b0);
    step(1'b1, 16'h5678, 1'b0);
    step(1'b1, 16'h9ABC, 1'b0);
    drain();

    // Valid held high against a full FIFO
    for (int i = 0; i < 40; i++) step(1'b1, 16'h1000 + 16'(i), 1'b0);
    drain();

    // Flush while in S2 with two words queued
    step(1'b1, 16'hDEAD, 1'b0);
    step(1'b1, 16'hBEEF, 1'b0);
    step(1'b1, 16'hCAFE, 1'b0);
    step(1'b0, 16'h0, 1'b1);
    #3;
    chk("flush_rdy", rdy, 1);
    drain();

    // Flush in S0 with coincident push
    step(1'b1, 16'hFFFF, 1'b1);
    #3;
    chk("flush_s0_idle", idle, 1);
    drain();

    // Asynchronous reset while in S2
    step(1'b1, 16'h7E81, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    rst = 1'b1;
    #1;
    chk("async_rst_enc", enc, 0);
    chk("async_rst_vld", enc_vld, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_idle", idle, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 16'h4321, 1'b0);
    drain();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 16'($urandom),
           ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0);
    end
    drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
